adam_mem_arb: RTL and testbench



---
 rtl/adam_mem_arb_pkg.sv | 9 +
 rtl/adam_rr_pick.sv | 22 ++
 rtl/adam_mem_arb.sv | 90 +++++++++
 tb/tb_adam_mem_arb.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/adam_mem_arb_pkg.sv
// adam_mem_arb_pkg: shared memory-bus types, arbiter limits and lock FSM states
package adam_mem_arb_pkg;
  typedef logic [31:0] ADDR_T;
  typedef logic [31:0] DATA_T;
  typedef logic [3:0]  STRB_T;
  localparam int NO_REQS_MAX = 8;
  typedef logic [3:0] LOCK_CNT_T;
  typedef enum logic {LK_IDLE, LK_LOCKED} lock_state_e;
endpackage

// File: rtl/adam_rr_pick.sv
// adam_rr_pick: round-robin priority encoder; first req&mask bit at or after ptr -> one-hot pick + idx
module adam_rr_pick #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx
);
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N] && mask[(int'(ptr) + i) % N]) begin
        pick = N'(1) << ((int'(ptr) + i) % N);
        idx  = IW'((int'(ptr) + i) % N);
      end
    end
  end
endmodule

// File: rtl/adam_mem_arb.sv
// adam_mem_arb: round-robin arbiter with bounded lock sharing one adam_mem port (clk, rstn, req/lock/addr/we/be/wdata in, gnt/rvalid/rdata out, mem_* to memory)
module adam_mem_arb
  import adam_mem_arb_pkg::*;
#(
  parameter int NO_REQS    = 2,
  parameter int ADDR_WIDTH = $bits(ADDR_T),
  parameter int DATA_WIDTH = $bits(DATA_T),
  parameter int LOCK_MAX   = 4
) (
  input  logic                                    clk,
  input  logic                                    rstn,
  input  logic [NO_REQS-1:0]                      req,
  input  logic [NO_REQS-1:0]                      lock,
  input  logic [NO_REQS-1:0][ADDR_WIDTH-1:0]      addr,
  input  logic [NO_REQS-1:0]                      we,
  input  logic [NO_REQS-1:0][DATA_WIDTH/8-1:0]    be,
  input  logic [NO_REQS-1:0][DATA_WIDTH-1:0]      wdata,
  output logic [NO_REQS-1:0]                      gnt,
  output logic [NO_REQS-1:0]                      rvalid,
  output logic [DATA_WIDTH-1:0]                   rdata,
  output logic                                    mem_req,
  output logic [ADDR_WIDTH-1:0]                   mem_addr,
  output logic                                    mem_we,
  output logic [DATA_WIDTH/8-1:0]                 mem_be,
  output logic [DATA_WIDTH-1:0]                   mem_wdata,
  input  logic [DATA_WIDTH-1:0]                   mem_rdata
);
  localparam int IW = $clog2(NO_REQS);
  lock_state_e state, state_n;
  logic [IW-1:0] last, owner, owner_n, start, pick_idx, win;
  logic [NO_REQS-1:0] pick_oh, own_oh, mask, resp_oh;
  LOCK_CNT_T cnt, cnt_n, cnt_inc;
  logic excl, excl_n, hit, any, keep;
  assign start   = (last == IW'(NO_REQS - 1)) ? '0 : last + 1'b1;
  assign own_oh  = NO_REQS'(1) << owner;
  // a timed-out owner sits out one cycle, but only if someone else wants the bus
  assign mask    = (excl && |(req & ~own_oh)) ? ~own_oh : '1;
  adam_rr_pick #(.N(NO_REQS)) u_pick (
    .req  (req),
    .ptr  (start),
    .mask (mask),
    .pick (pick_oh),
    .idx  (pick_idx)
  );
  assign hit       = (state == LK_LOCKED) && req[owner];
  assign any       = rstn && |req;
  assign win       = hit ? owner : pick_idx;
  assign gnt       = !any ? '0 : hit ? own_oh : pick_oh;
  assign mem_req   = any;
  assign mem_addr  = any ? addr[win] : '0;
  assign mem_we    = any && we[win];
  assign mem_be    = any ? be[win] : '0;
  assign mem_wdata = any ? wdata[win] : '0;
  assign rvalid    = resp_oh;
  assign rdata     = mem_rdata;
  assign cnt_inc   = (cnt == '1) ? cnt : cnt + 1'b1;
  assign keep      = lock[owner] && (cnt_inc < LOCK_CNT_T'(LOCK_MAX));
  always_comb begin
    state_n = LK_IDLE;
    owner_n = owner;
    cnt_n   = '0;
    excl_n  = 1'b0;
    if (hit) begin
      state_n = keep ? LK_LOCKED : LK_IDLE;
      cnt_n   = keep ? cnt_inc : '0;
      excl_n  = lock[owner] && !keep;
    end else if (any && lock[win] && LOCK_MAX > 1) begin
      state_n = LK_LOCKED;
      owner_n = win;
      cnt_n   = LOCK_CNT_T'(1);
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= LK_IDLE;
      owner   <= '0;
      cnt     <= '0;
      excl    <= 1'b0;
      last    <= IW'(NO_REQS - 1);
      resp_oh <= '0;
    end else begin
      state   <= state_n;
      owner   <= owner_n;
      cnt     <= cnt_n;
      excl    <= excl_n;
      resp_oh <= gnt;
      if (any) last <= win;
    end
  end
endmodule

// File: tb/tb_adam_mem_arb.sv
// tb_adam_mem_arb: table-driven, directed and random checks of adam_mem_arb against a behavioural model
module tb_adam_mem_arb;
  localparam int N = 2, AW = 32, DW = 32, SW = DW / 8, LM = 4;
  logic clk = 0, rstn = 0;
  logic [N-1:0] req = '0, lock = '0, we = '0, gnt, rvalid;
  logic [N-1:0][AW-1:0] addr = '0;
  logic [N-1:0][SW-1:0] be = '0;
  logic [N-1:0][DW-1:0] wdata = '0;
  logic [DW-1:0] rdata, mem_rdata = '0, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_be;
  logic mem_req, mem_we;
  int checks = 0, failures = 0;
  logic [DW-1:0] mem [16];
  logic [DW-1:0] ref_mem [16];
  int m_last, m_owner, m_cnt, m_excl;
  logic [N-1:0] m_rv;
  bit m_rd_ok;
  logic [DW-1:0] m_rd;
  typedef struct { logic [N-1:0] req, lock, gnt; } vec_t;
  vec_t tv[$];

  adam_mem_arb #(.NO_REQS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(LM)) dut (
    .clk(clk), .rstn(rstn), .req(req), .lock(lock), .addr(addr), .we(we), .be(be),
    .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we)
        for (int b = 0; b < SW; b++)
          if (mem_be[b]) mem[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= mem[mem_addr[5:2]];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_last = N - 1; m_owner = -1; m_cnt = 0; m_excl = -1;
    m_rv = '0; m_rd_ok = 0; m_rd = '0;
  endtask

  function automatic int m_win(input logic [N-1:0] r);
    if (m_owner >= 0 && r[m_owner]) return m_owner;
    for (int i = 1; i <= N; i++) begin
      int k = (m_last + i) % N;
      if (r[k] && !(k == m_excl && (r & ~(N'(1) << k)) != '0)) return k;
    end
    return -1;
  endfunction

  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N-1:0] tg, input bit use_t);
    int w, nx;
    logic [N-1:0] eg;
    logic [3:0] ix;
    req = r; lock = l;
    #1;
    w  = m_win(r);
    eg = (w >= 0) ? N'(1) << w : '0;
    chk("gnt", gnt, eg);
    if (use_t) chk("tbl_gnt", gnt, tg);
    chk("mem_req", mem_req, w >= 0);
    chk("mem_addr", mem_addr, (w >= 0) ? addr[w] : '0);
    chk("mem_we", mem_we, (w >= 0) ? we[w] : 1'b0);
    chk("mem_be", mem_be, (w >= 0) ? be[w] : '0);
    chk("mem_wdata", mem_wdata, (w >= 0) ? wdata[w] : '0);
    chk("rvalid", rvalid, m_rv);
    if (m_rd_ok) chk("rdata", rdata, m_rd);
    m_rv = eg;
    m_rd_ok = (w >= 0) && !we[w];
    nx = -1;
    if (w >= 0) begin
      ix = addr[w][5:2];
      m_rd = ref_mem[ix];
      if (we[w])
        for (int b = 0; b < SW; b++)
          if (be[w][b]) ref_mem[ix][8*b +: 8] = wdata[w][8*b +: 8];
      if (w == m_owner) begin
        m_cnt++;
        if (!l[w]) m_owner = -1;
        else if (m_cnt >= LM) begin m_owner = -1; nx = w; end
      end else begin
        m_owner = (l[w] && LM > 1) ? w : -1;
        m_cnt = 1;
      end
      m_last = w;
    end else m_owner = -1;
    m_excl = nx;
    @(negedge clk);
  endtask

  task automatic add(input logic [N-1:0] r, input logic [N-1:0] l, input logic [N-1:0] g, input int n);
    vec_t v;
    v.req = r; v.lock = l; v.gnt = g;
    for (int i = 0; i < n; i++) tv.push_back(v);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin mem[i] = '0; ref_mem[i] = '0; end
    model_reset();
    req = 2'b11;
    @(negedge clk);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_mem_req", mem_req, 1'b0);
    chk("rst_rvalid", rvalid, 2'b00);
    req = '0;
    @(negedge clk);
    rstn = 1;
    add(2'b00, 2'b00, 2'b00, 10);
    for (int i = 0; i < 3; i++) begin add(2'b11, 2'b00, 2'b01, 1); add(2'b11, 2'b00, 2'b10, 1); end
    for (int i = 0; i < 2; i++) begin add(2'b11, 2'b01, 2'b01, 4); add(2'b11, 2'b01, 2'b10, 1); end
    add(2'b11, 2'b01, 2'b01, 1); add(2'b11, 2'b00, 2'b01, 1); add(2'b11, 2'b00, 2'b10, 1);
    add(2'b11, 2'b01, 2'b01, 1); add(2'b11, 2'b11, 2'b01, 3); add(2'b11, 2'b00, 2'b10, 1);
    add(2'b11, 2'b01, 2'b01, 1); add(2'b10, 2'b01, 2'b10, 1); add(2'b11, 2'b00, 2'b01, 1);
    foreach (tv[i]) cyc(tv[i].req, tv[i].lock, tv[i].gnt, 1);
    addr[0] = 32'h10; we[0] = 1; be[0] = 4'hF; wdata[0] = 32'hDEADBEEF;
    cyc(2'b01, 2'b00, 2'b01, 1);
    addr[1] = 32'h10; we[1] = 0;
    cyc(2'b10, 2'b00, 2'b10, 1);
    req = '0; #1;
    chk("route_rvalid", rvalid, 2'b10);
    chk("route_rdata", rdata, 32'hDEADBEEF);
    cyc(2'b00, 2'b00, 2'b00, 0);
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        addr[i] = 32'($urandom_range(0, 15)) << 2;
        we[i] = 1'($urandom);
        be[i] = SW'($urandom);
        wdata[i] = $urandom;
      end
      cyc(N'($urandom), ($urandom_range(0, 3) == 0) ? N'($urandom) : '0, '0, 0);
    end
    rstn = 0; #1;
    model_reset();
    @(negedge clk);
    rstn = 1;
    we = '0;
    cyc(2'b11, 2'b01, 2'b01, 1);
    cyc(2'b11, 2'b01, 2'b01, 1);
    rstn = 0; #1;
    chk("midrst_rvalid", rvalid, 2'b00);
    chk("midrst_gnt", gnt, 2'b00);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rstn = 1;
    cyc(2'b11, 2'b00, 2'b01, 1);
    cyc(2'b11, 2'b00, 2'b10, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
